// File: rtl/bp_cacc_pkg.sv
// Shared CSR indices, ctrl/status bit positions and FSM states for the streaming
// vector dot-product engine.
package bp_cacc_pkg;

  localparam logic [2:0] vdp_aptr_idx_gp   = 3'd0;
  localparam logic [2:0] vdp_bptr_idx_gp   = 3'd1;
  localparam logic [2:0] vdp_len_idx_gp    = 3'd2;
  localparam logic [2:0] vdp_resptr_idx_gp = 3'd3;
  localparam logic [2:0] vdp_ctrl_idx_gp   = 3'd4;
  localparam logic [2:0] vdp_status_idx_gp = 3'd5;
  localparam logic [2:0] vdp_result_idx_gp = 3'd6;

  localparam int ctrl_start_bit_gp  = 0;
  localparam int ctrl_signed_bit_gp = 1;
  localparam int ctrl_sum_bit_gp    = 2;

  localparam int status_busy_bit_gp = 0;
  localparam int status_done_bit_gp = 1;
  localparam int status_err_bit_gp  = 2;

  typedef enum logic [3:0] {
    e_idle,
    e_req_a,
    e_wait_a,
    e_req_b,
    e_wait_b,
    e_mac,
    e_req_wb,
    e_wait_wb,
    e_done
  } vdp_state_e;

endpackage

// File: rtl/bp_cacc_simd_mac.sv
// Combinational lane-masked SIMD multiply and reduce over one 64-bit dword.
// Zero latency, no flow control; result wraps at acc_width_p bits.
module bp_cacc_simd_mac #(
  parameter int elem_width_p = 16,
  parameter int acc_width_p  = 64
) (
  input  logic [63:0]                 a,
  input  logic [63:0]                 b,
  input  logic [64/elem_width_p-1:0]  lane_mask,
  input  logic                        is_signed,
  output logic [acc_width_p-1:0]      lane_sum
);

  localparam int lanes_lp = 64 / elem_width_p;
  localparam int prod_w_lp = 2 * elem_width_p;

  logic [prod_w_lp-1:0] pa, pb, prod;

  // Operands widened to the product width so the truncated product is exact.
  always_comb begin
    lane_sum = '0;
    pa = '0;
    pb = '0;
    prod = '0;
    for (int i = 0; i < lanes_lp; i++) begin
      pa = is_signed ? prod_w_lp'($signed(a[i*elem_width_p +: elem_width_p]))
                     : prod_w_lp'(a[i*elem_width_p +: elem_width_p]);
      pb = is_signed ? prod_w_lp'($signed(b[i*elem_width_p +: elem_width_p]))
                     : prod_w_lp'(b[i*elem_width_p +: elem_width_p]);
      prod = pa * pb;
      if (lane_mask[i]) begin
        lane_sum = lane_sum + (is_signed ? acc_width_p'($signed(prod)) : acc_width_p'(prod));
      end
    end
  end

endmodule

// File: rtl/bp_cacc_vdp_stream.sv
// CSR-programmed streaming dot product: fetches A/B dwords one at a time, MACs, stores the result.
// One memory transaction outstanding; requests hold until mem_req_ready_i, waits for mem_resp_v_i.
module bp_cacc_vdp_stream
  import bp_cacc_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int elem_width_p  = 16,
  parameter int acc_width_p   = 64,
  parameter int len_width_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     csr_w_v_i,
  input  logic                     csr_r_v_i,
  input  logic [2:0]               csr_addr_i,
  input  logic [63:0]              csr_data_i,
  output logic [63:0]              csr_data_o,
  output logic                     csr_r_v_o,
  output logic                     mem_req_v_o,
  input  logic                     mem_req_ready_i,
  output logic                     mem_req_we_o,
  output logic [paddr_width_p-1:0] mem_req_addr_o,
  output logic [63:0]              mem_req_data_o,
  input  logic                     mem_resp_v_i,
  input  logic [63:0]              mem_resp_data_i,
  output logic                     done_o
);

  localparam int lanes_lp = 64 / elem_width_p;
  localparam int lg_lp    = $clog2(lanes_lp);

  vdp_state_e state_r, state_n;

  logic [paddr_width_p-1:0] a_ptr_r, b_ptr_r, res_ptr_r, word_off;
  logic [len_width_p-1:0]   len_r, word_r;
  logic [len_width_p:0]     words_total;
  logic [lg_lp-1:0]         rem;
  logic                     signed_r, sum_only_r, done_r, err_r;
  logic [acc_width_p-1:0]   acc_r, lane_sum;
  logic [63:0]              a_word_r, b_word_r, result_r, acc_ext, rd_data, b_operand;
  logic [lanes_lp-1:0]      lane_mask;
  logic                     busy, start_go, misaligned, last_word, in_wait;

  assign busy       = (state_r != e_idle);
  assign start_go   = csr_w_v_i && (csr_addr_i == vdp_ctrl_idx_gp)
                      && csr_data_i[ctrl_start_bit_gp] && !busy;
  assign misaligned = |{a_ptr_r[2:0], b_ptr_r[2:0], res_ptr_r[2:0]};
  assign in_wait    = (state_r == e_wait_a) || (state_r == e_wait_b) || (state_r == e_wait_wb);

  assign words_total = ({1'b0, len_r} + (len_width_p+1)'(lanes_lp - 1)) >> lg_lp;
  assign last_word   = (({1'b0, word_r} + (len_width_p+1)'(1)) == words_total);
  assign rem         = len_r[lg_lp-1:0];
  assign word_off    = paddr_width_p'({word_r, 3'b000});
  assign acc_ext     = signed_r ? 64'($signed(acc_r)) : 64'(acc_r);
  assign b_operand   = sum_only_r ? {lanes_lp{elem_width_p'(1)}} : b_word_r;

  // Tail lanes beyond len are only masked on the final word of a ragged vector.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < lanes_lp; i++) begin
      lane_mask[i] = !last_word || (rem == '0) || (lg_lp'(i) < rem);
    end
  end

  bp_cacc_simd_mac #(
    .elem_width_p(elem_width_p),
    .acc_width_p (acc_width_p)
  ) simd_mac (
    .a        (a_word_r),
    .b        (b_operand),
    .lane_mask(lane_mask),
    .is_signed(signed_r),
    .lane_sum (lane_sum)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n        = state_r;
    mem_req_v_o    = 1'b0;
    mem_req_we_o   = 1'b0;
    mem_req_addr_o = '0;
    mem_req_data_o = '0;
    done_o         = 1'b0;
    unique case (state_r)
      e_idle: begin
        if (start_go) begin
          if (misaligned)         state_n = e_done;
          else if (len_r == '0)   state_n = e_req_wb;
          else                    state_n = e_req_a;
        end
      end
      e_req_a: begin
        mem_req_v_o    = 1'b1;
        mem_req_addr_o = a_ptr_r + word_off;
        if (mem_req_ready_i) state_n = e_wait_a;
      end
      e_wait_a:  if (mem_resp_v_i) state_n = sum_only_r ? e_mac : e_req_b;
      e_req_b: begin
        mem_req_v_o    = 1'b1;
        mem_req_addr_o = b_ptr_r + word_off;
        if (mem_req_ready_i) state_n = e_wait_b;
      end
      e_wait_b:  if (mem_resp_v_i) state_n = e_mac;
      e_mac:     state_n = last_word ? e_req_wb : e_req_a;
      e_req_wb: begin
        mem_req_v_o    = 1'b1;
        mem_req_we_o   = 1'b1;
        mem_req_addr_o = res_ptr_r;
        mem_req_data_o = acc_ext;
        if (mem_req_ready_i) state_n = e_wait_wb;
      end
      e_wait_wb: if (mem_resp_v_i) state_n = e_done;
      e_done: begin
        done_o  = 1'b1;
        state_n = e_idle;
      end
      default:   state_n = e_idle;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (csr_addr_i)
      vdp_aptr_idx_gp:   rd_data = 64'(a_ptr_r);
      vdp_bptr_idx_gp:   rd_data = 64'(b_ptr_r);
      vdp_len_idx_gp:    rd_data = 64'(len_r);
      vdp_resptr_idx_gp: rd_data = 64'(res_ptr_r);
      vdp_ctrl_idx_gp: begin
        rd_data[ctrl_signed_bit_gp] = signed_r;
        rd_data[ctrl_sum_bit_gp]    = sum_only_r;
      end
      vdp_status_idx_gp: begin
        rd_data[status_busy_bit_gp] = busy;
        rd_data[status_done_bit_gp] = done_r;
        rd_data[status_err_bit_gp]  = err_r;
      end
      vdp_result_idx_gp: rd_data = result_r;
      default:           rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csr_r_v_o  <= 1'b0;
      csr_data_o <= '0;
      a_ptr_r    <= '0;
      b_ptr_r    <= '0;
      res_ptr_r  <= '0;
      len_r      <= '0;
      word_r     <= '0;
      signed_r   <= 1'b0;
      sum_only_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      acc_r      <= '0;
      a_word_r   <= '0;
      b_word_r   <= '0;
      result_r   <= '0;
    end else begin
      csr_r_v_o  <= csr_r_v_i;
      csr_data_o <= csr_r_v_i ? rd_data : '0;
      if (csr_w_v_i && !busy) begin
        case (csr_addr_i)
          vdp_aptr_idx_gp:   a_ptr_r   <= csr_data_i[paddr_width_p-1:0];
          vdp_bptr_idx_gp:   b_ptr_r   <= csr_data_i[paddr_width_p-1:0];
          vdp_len_idx_gp:    len_r     <= csr_data_i[len_width_p-1:0];
          vdp_resptr_idx_gp: res_ptr_r <= csr_data_i[paddr_width_p-1:0];
          vdp_ctrl_idx_gp: begin
            signed_r   <= csr_data_i[ctrl_signed_bit_gp];
            sum_only_r <= csr_data_i[ctrl_sum_bit_gp];
          end
          default: ;
        endcase
      end
      if (start_go) begin
        done_r <= 1'b0;
        err_r  <= misaligned;
        acc_r  <= '0;
        word_r <= '0;
      end
      if (state_r == e_wait_a && mem_resp_v_i) a_word_r <= mem_resp_data_i;
      if (state_r == e_wait_b && mem_resp_v_i) b_word_r <= mem_resp_data_i;
      if (state_r == e_mac) begin
        acc_r  <= acc_r + lane_sum;
        word_r <= word_r + len_width_p'(1);
      end
      if (state_r == e_wait_wb && mem_resp_v_i) begin
        result_r <= acc_ext;
        done_r   <= 1'b1;
      end
      // A response with nothing outstanding means the memory side is confused.
      if (mem_resp_v_i && !in_wait) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_cacc_vdp_stream.sv
// Scoreboard bench: stimulus queues expected CSR reads and stores, a monitor pops and compares.
// Two DUTs (16-bit and 8-bit elements) share one memory model through a select mux.
module tb_bp_cacc_vdp_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        csr_w_v = 1'b0, csr_r_v = 1'b0, sel8 = 1'b0;
  logic [2:0]  csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic        ready = 1'b0, resp_v = 1'b0;
  logic [63:0] resp_data = '0;

  logic [63:0] rd16, rd8, wd16, wd8;
  logic [39:0] ad16, ad8;
  logic        rv16, rv8, v16, v8, we16, we8, dn16, dn8;

  bp_cacc_vdp_stream dut16 (
    .clk_i(clk), .reset_n_i(rst_n),
    .csr_w_v_i(csr_w_v & ~sel8), .csr_r_v_i(csr_r_v & ~sel8),
    .csr_addr_i(csr_addr), .csr_data_i(csr_wdata),
    .csr_data_o(rd16), .csr_r_v_o(rv16),
    .mem_req_v_o(v16), .mem_req_ready_i(ready & ~sel8), .mem_req_we_o(we16),
    .mem_req_addr_o(ad16), .mem_req_data_o(wd16),
    .mem_resp_v_i(resp_v & ~sel8), .mem_resp_data_i(resp_data),
    .done_o(dn16)
  );

  bp_cacc_vdp_stream #(.elem_width_p(8)) dut8 (
    .clk_i(clk), .reset_n_i(rst_n),
    .csr_w_v_i(csr_w_v & sel8), .csr_r_v_i(csr_r_v & sel8),
    .csr_addr_i(csr_addr), .csr_data_i(csr_wdata),
    .csr_data_o(rd8), .csr_r_v_o(rv8),
    .mem_req_v_o(v8), .mem_req_ready_i(ready & sel8), .mem_req_we_o(we8),
    .mem_req_addr_o(ad8), .mem_req_data_o(wd8),
    .mem_resp_v_i(resp_v & sel8), .mem_resp_data_i(resp_data),
    .done_o(dn8)
  );

  logic [63:0] m_rdata, m_wdata;
  logic [39:0] m_addr;
  logic        m_rv, m_v, m_we, m_done;
  assign m_rdata = sel8 ? rd8 : rd16;
  assign m_rv    = sel8 ? rv8 : rv16;
  assign m_v     = sel8 ? v8 : v16;
  assign m_we    = sel8 ? we8 : we16;
  assign m_addr  = sel8 ? ad8 : ad16;
  assign m_wdata = sel8 ? wd8 : wd16;
  assign m_done  = sel8 ? dn8 : dn16;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [39:0] addr; logic [63:0] data; } st_t;
  logic [63:0] rd_q[$];
  st_t         st_q[$];

  logic [63:0] mem [0:1023];
  int req_cnt = 0, done_cnt = 0, stall_cfg = 0;

  // Memory model: optional stall per request, response one cycle after acceptance.
  initial begin
    int stall_cnt;
    logic pend, stalled;
    logic [63:0] pend_data, sv_data;
    logic [39:0] sv_addr;
    stall_cnt = 0; pend = 0; stalled = 0; pend_data = '0; sv_data = '0; sv_addr = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        ready = 0; resp_v = 0; pend = 0; stalled = 0; stall_cnt = 0;
      end else begin
        resp_v = 0;
        if (pend) begin resp_v = 1; resp_data = pend_data; pend = 0; end
        if (stalled && m_v) begin
          check("hold_addr", 64'(m_addr), 64'(sv_addr));
          check("hold_data", m_wdata, sv_data);
        end
        ready = 0; stalled = 0;
        if (m_v) begin
          if (stall_cnt < stall_cfg) begin
            stall_cnt++; stalled = 1; sv_addr = m_addr; sv_data = m_wdata;
          end else begin
            ready = 1; stall_cnt = 0; req_cnt++; pend = 1;
            pend_data = m_we ? 64'h0 : mem[m_addr[12:3]];
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_done) done_cnt++;
  end

  // Monitor: compares every CSR read return and every accepted store against the queues.
  initial forever begin
    @(negedge clk);
    if (m_rv) begin
      if (rd_q.size() == 0) check("csr_read_unexpected", 64'h1, 64'h0);
      else check("csr_read", m_rdata, rd_q.pop_front());
    end
    if (m_v && ready && m_we) begin
      if (st_q.size() == 0) check("store_unexpected", 64'(m_addr), 64'h0);
      else begin
        st_t e;
        e = st_q.pop_front();
        check("store_addr", 64'(m_addr), 64'(e.addr));
        check("store_data", m_wdata, e.data);
      end
    end
  end

  task automatic csr_wr(input logic [2:0] idx, input logic [63:0] d);
    @(posedge clk); #1;
    csr_w_v = 1; csr_addr = idx; csr_wdata = d;
    @(posedge clk); #1;
    csr_w_v = 0;
  endtask

  task automatic csr_rd(input logic [2:0] idx, input logic [63:0] exp);
    @(posedge clk); #1;
    csr_r_v = 1; csr_addr = idx;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    csr_r_v = 0;
  endtask

  task automatic setup(input logic [63:0] a, b, len, res);
    csr_wr(3'd0, a); csr_wr(3'd1, b); csr_wr(3'd2, len); csr_wr(3'd3, res);
  endtask

  int d0 = 0, r0 = 0;
  task automatic start_op(input logic [63:0] ctrl);
    d0 = done_cnt; r0 = req_cnt;
    csr_wr(3'd4, ctrl);
  endtask

  task automatic wait_op(input string name, input int exp_reqs);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_requests"}, 64'(req_cnt - r0), 64'(exp_reqs));
  endtask

  function automatic st_t mk(input logic [39:0] a, input logic [63:0] d);
    st_t s;
    s.addr = a; s.data = d;
    return s;
  endfunction

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h020] = 64'h0004_0003_0002_0001;  // A at 0x100
    mem[10'h040] = 64'h0008_0007_0006_0005;  // B at 0x200
    mem[10'h080] = 64'hFFFF_FFFF_FFFF_FFFF;  // A at 0x400
    mem[10'h081] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[10'h0A0] = 64'h0002_0002_0002_0002;  // B at 0x500
    mem[10'h0A1] = 64'h0002_0002_0002_0002;
    mem[10'h0E0] = 64'h0807_0605_0403_0201;  // 8-bit A at 0x700

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_v", 64'(m_v), 64'h0);
    check("rst_done", 64'(m_done), 64'h0);
    check("rst_csr_r_v", 64'(m_rv), 64'h0);
    rst_n = 1;
    csr_rd(3'd5, 64'h0);
    csr_rd(3'd6, 64'h0);
    csr_rd(3'd0, 64'h0);

    // Unsigned 4-element dot product: 5+12+21+32
    setup(64'h100, 64'h200, 64'd4, 64'h300);
    st_q.push_back(mk(40'h300, 64'd70));
    start_op(64'h1);
    wait_op("basic", 3);
    csr_rd(3'd6, 64'd70);
    csr_rd(3'd5, 64'h2);

    // Ragged len 6: only lanes 0-1 of the second word count
    setup(64'h400, 64'h500, 64'd6, 64'h600);
    st_q.push_back(mk(40'h600, 64'hFFFF_FFFF_FFFF_FFF4));
    start_op(64'h3);
    wait_op("signed_tail", 5);
    csr_rd(3'd6, 64'hFFFF_FFFF_FFFF_FFF4);
    st_q.push_back(mk(40'h600, 64'hB_FFF4));
    start_op(64'h1);
    wait_op("unsigned_tail", 5);
    csr_rd(3'd6, 64'hB_FFF4);

    // Zero length: single store of 0
    setup(64'h100, 64'h200, 64'd0, 64'h1000);
    st_q.push_back(mk(40'h1000, 64'h0));
    start_op(64'h1);
    wait_op("len0", 1);
    csr_rd(3'd5, 64'h2);

    // Misaligned A pointer: err, done pulse, no traffic; next start clears err
    setup(64'h1004, 64'h200, 64'd4, 64'h300);
    start_op(64'h1);
    wait_op("misaligned", 0);
    csr_rd(3'd5, 64'h4);
    csr_wr(3'd0, 64'h100);
    st_q.push_back(mk(40'h300, 64'd70));
    start_op(64'h1);
    wait_op("recover", 3);
    csr_rd(3'd5, 64'h2);

    // Backpressure on every request plus a dropped write while busy
    stall_cfg = 5;
    st_q.push_back(mk(40'h300, 64'd70));
    start_op(64'h1);
    csr_wr(3'd0, 64'h700);
    wait_op("stall", 3);
    stall_cfg = 0;
    csr_rd(3'd0, 64'h100);
    csr_rd(3'd6, 64'd70);

    // Reset while waiting for the B load
    start_op(64'h1);
    t = 0;
    while (req_cnt - r0 != 2 && t < 500) begin @(posedge clk); t++; end
    check("reach_wait_b", 64'(req_cnt - r0), 64'd2);
    #1;
    rst_n = 0;
    #1;
    check("midrst_req_v", 64'(m_v), 64'h0);
    check("midrst_addr", 64'(m_addr), 64'h0);
    check("midrst_done", 64'(m_done), 64'h0);
    @(posedge clk); #1;
    rst_n = 1;
    csr_rd(3'd5, 64'h0);
    setup(64'h100, 64'h200, 64'd4, 64'h300);
    st_q.push_back(mk(40'h300, 64'd70));
    start_op(64'h1);
    wait_op("after_reset", 3);
    csr_rd(3'd6, 64'd70);

    // 8-bit elements, sum only: 1+2+...+8
    @(posedge clk); #1;
    sel8 = 1;
    setup(64'h700, 64'h0, 64'd8, 64'h708);
    st_q.push_back(mk(40'h708, 64'd36));
    start_op(64'h5);
    wait_op("sum8", 2);
    csr_rd(3'd6, 64'd36);

    repeat (4) @(posedge clk);
    #1;
    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    check("st_q_drained", 64'(st_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
